// File: rtl/dma_copy_engine.sv
// dma_copy_engine: copies a block of words from a synchronous-read ROM into a RAM.
// Reads are issued one per cycle. Each write follows its read by one cycle and
// takes its data straight from the ROM output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; done/aborted pulse here for one cycle
// RUN   | issuing reads (one per cycle) and the writes of earlier reads
// FLUSH | last read already issued; performing the final write only
module dma_copy_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int SRC_AW     = 4,
  parameter int DST_AW     = 8,
  parameter int LEN_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SRC_AW-1:0]     src_base,
  input  logic [DST_AW-1:0]     dst_base,
  input  logic [LEN_W-1:0]      len,
  output logic [SRC_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DST_AW-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_W-1:0]      xfer_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SRC_AW-1:0] rom_addr_nxt;
  logic [DST_AW-1:0] ram_addr_nxt;
  logic [DST_AW-1:0] dst_ptr, dst_ptr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [LEN_W-1:0]  xfer_count_nxt;
  logic              ram_we_nxt;
  logic              done_nxt;
  logic              aborted_nxt;

  // Write data needs no register: the ROM output already lines up with the write cycle.
  assign ram_din = rom_data;
  assign busy    = (state != IDLE);

  // State and datapath registers; reset clears every visible output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      ram_addr   <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      xfer_count <= '0;
      ram_we     <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rom_addr   <= rom_addr_nxt;
      ram_addr   <= ram_addr_nxt;
      dst_ptr    <= dst_ptr_nxt;
      remaining  <= remaining_nxt;
      xfer_count <= xfer_count_nxt;
      ram_we     <= ram_we_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    rom_addr_nxt  = rom_addr;
    ram_addr_nxt  = ram_addr;
    dst_ptr_nxt   = dst_ptr;
    remaining_nxt = remaining;
    ram_we_nxt    = 1'b0;
    done_nxt      = 1'b0;
    aborted_nxt   = 1'b0;
    // A write that is on the bus during this cycle always completes, including
    // one that overlaps an abort, so it is counted at the edge ending it.
    xfer_count_nxt = xfer_count + {{(LEN_W-1){1'b0}}, ram_we};

    case (state)
      IDLE: begin
        if (start) begin
          xfer_count_nxt = '0;
          if (len != '0) begin
            state_nxt     = RUN;
            rom_addr_nxt  = src_base;
            dst_ptr_nxt   = dst_base;
            remaining_nxt = len;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt   = IDLE;
          aborted_nxt = 1'b1;
        end else begin
          // The read presented this cycle turns into a write next cycle.
          ram_we_nxt    = 1'b1;
          ram_addr_nxt  = dst_ptr;
          dst_ptr_nxt   = dst_ptr + {{(DST_AW-1){1'b0}}, 1'b1};
          remaining_nxt = remaining - {{(LEN_W-1){1'b0}}, 1'b1};
          if (remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_nxt = FLUSH;
          end else begin
            rom_addr_nxt = rom_addr + {{(SRC_AW-1){1'b0}}, 1'b1};
          end
        end
      end

      FLUSH: begin
        state_nxt = IDLE;
        if (abort) begin
          aborted_nxt = 1'b1;
        end else begin
          done_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed and randomized copies with an expectation
// scoreboard. The driver predicts each write and the completion event from
// block-level rules; a monitor pops and compares them as the DUT produces them.
module tb_dma_copy_engine;

  localparam int DW  = 8;
  localparam int SAW = 4;
  localparam int DAW = 8;
  localparam int LW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [SAW-1:0] src_base;
  logic [DAW-1:0] dst_base;
  logic [LW-1:0]  len;
  logic [SAW-1:0] rom_addr;
  logic [DW-1:0]  rom_data;
  logic [DAW-1:0] ram_addr;
  logic [DW-1:0]  ram_din;
  logic           ram_we;
  logic           busy;
  logic           done;
  logic           aborted;
  logic [LW-1:0]  xfer_count;

  dma_copy_engine #(
    .DATA_WIDTH(DW), .SRC_AW(SAW), .DST_AW(DAW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .busy(busy), .done(done), .aborted(aborted), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM: data for an address appears one cycle later.
  logic [DW-1:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Edge counter: after the edge that samples start (t0), cycle n has cyc == t0+n-1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endfunction

  typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; bit is_abort; int cnt; } ev_t;
  wr_t wq[$];
  ev_t eq[$];
  int busy_lo = 1;
  int busy_hi = 0;

  // Monitor: compares every visible write and completion pulse with the scoreboard.
  initial begin
    wr_t w;
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
        if (ram_we) begin
          if (wq.size() == 0) check("unexpected_write", ram_we, 0);
          else begin
            w = wq.pop_front();
            check("wr_cycle", cyc, w.cyc);
            check("wr_addr", ram_addr, w.addr);
            check("wr_data", ram_din, w.data);
          end
        end
        if (done || aborted) begin
          check("done_aborted_exclusive", done && aborted, 0);
          if (eq.size() == 0) check("unexpected_end", {done, aborted}, 0);
          else begin
            e = eq.pop_front();
            check("end_cycle", cyc, e.cyc);
            check("end_kind_aborted", aborted, e.is_abort);
            check("end_xfer_count", xfer_count, e.cnt);
          end
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (wq.size() == 0 && eq.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", wq.size() + eq.size(), 0);
  endtask

  // One transfer. ab: cycle in which abort is held (0 = none);
  // rs: cycle in which start is pulsed again (0 = none); abst: abort together with start.
  task automatic run_xfer(input int src, input int dst, input int l,
                          input int ab, input int rs, input bit abst);
    int t0, nwr, cnt;
    ev_t e;
    if (l == 0) ab = 0;
    @(negedge clk);
    t0  = cyc + 1;
    nwr = (ab == 0) ? l : ((ab - 1 < l) ? ab - 1 : l);
    for (int k = 0; k < nwr; k++)
      wq.push_back('{t0 + k + 1, 8'((dst + k) % 256), rom[(src + k) % 16]});
    if (l == 0) begin
      e = '{t0, 1'b0, 0};
      busy_lo = 1; busy_hi = 0;
    end else if (ab != 0) begin
      e = '{t0 + ab, 1'b1, nwr};
      busy_lo = t0; busy_hi = t0 + ab - 1;
    end else begin
      e = '{t0 + l + 1, 1'b0, l};
      busy_lo = t0; busy_hi = t0 + l;
    end
    eq.push_back(e);
    cnt = e.cnt;
    src_base = SAW'(src); dst_base = DAW'(dst); len = LW'(l);
    start = 1'b1; abort = abst;
    for (int c = 1; c <= l + 4; c++) begin
      @(negedge clk);
      start = (rs == c);
      abort = (ab == c);
      src_base = SAW'($urandom); dst_base = DAW'($urandom); len = LW'($urandom);
    end
    start = 1'b0; abort = 1'b0;
    drain();
    check("xfer_count_hold", xfer_count, cnt);
  endtask

  initial begin
    int s, d, l, ab, rs;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; len = '0;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    #1;
    check("reset_outputs", {busy, done, aborted, ram_we, rom_addr, ram_addr, xfer_count}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    rom[2] = 8'hA1; rom[3] = 8'hB2; rom[4] = 8'hC3; rom[5] = 8'hD4;
    run_xfer(2, 8'h10, 4, 0, 0, 0);
    run_xfer(7, 8'h33, 0, 0, 0, 0);
    run_xfer(14, 8'hFE, 4, 0, 0, 0);
    run_xfer(1, 8'h40, 8, 4, 0, 0);
    run_xfer(9, 8'h80, 5, 0, 3, 0);
    run_xfer(5, 8'h20, 3, 0, 0, 1);
    run_xfer(11, 8'hF0, 4, 5, 0, 0);
    run_xfer(3, 8'h50, 6, 1, 0, 0);

    // Abort while idle must produce nothing.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); abort = 1'b1;
    end
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    check("idle_abort_no_pulse", {aborted, busy}, 0);

    // Asynchronous reset in the middle of write 2 of a six-word copy.
    @(negedge clk);
    begin
      int t0;
      t0 = cyc + 1;
      wq.push_back('{t0 + 1, 8'h60, rom[4]});
      wq.push_back('{t0 + 2, 8'h61, rom[5]});
      busy_lo = t0; busy_hi = t0 + 6;
      src_base = 4'd4; dst_base = 8'h60; len = 5'd6; start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk); start = 1'b0;
      end
      @(posedge clk);
      #3;
      check("write2_on_bus", {ram_we, ram_addr}, {1'b1, 8'h62});
      busy_hi = cyc - 1;
      rst = 1'b1;
      #1;
      check("async_reset_outputs",
            {busy, done, aborted, ram_we, rom_addr, ram_addr, xfer_count}, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("reset_no_leftover", wq.size() + eq.size(), 0);
    end

    for (int n = 0; n < 12; n++) begin
      s  = $urandom_range(0, 15);
      d  = $urandom_range(0, 255);
      l  = $urandom_range(0, 31);
      ab = (l > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, l + 1) : 0;
      rs = (l >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(2, l + 1) : 0;
      if (ab != 0 && rs > ab) rs = 0;
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      run_xfer(s, d, l, ab, rs, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of ROM read data and RAM write data.
REQ-002 Parameter SRC_AW, default 4, ROM address width.
REQ-003 Parameter DST_AW, default 8, RAM address width.
REQ-004 Parameter LEN_W, default 5, width of the transfer length field; max length 2^LEN_W-1 words.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request transfer; sampled only in IDLE.
REQ-008 abort  in  1  terminate active transfer.
REQ-009 src_base  in  SRC_AW  first ROM address.
REQ-010 dst_base  in  DST_AW  first RAM address.
REQ-011 len  in  LEN_W  number of words to copy.
REQ-012 rom_addr  out  SRC_AW  registered ROM read address.
REQ-013 rom_data  in  DATA_WIDTH  ROM read data, valid one cycle after rom_addr.
REQ-014 ram_addr  out  DST_AW  registered RAM write address.
REQ-015 ram_din  out  DATA_WIDTH  RAM write data, combinationally equal to rom_data.
REQ-016 ram_we  out  1  registered RAM write enable.
REQ-017 busy  out  1  high while a transfer is in progress.
REQ-018 done  out  1  one-cycle pulse on normal completion.
REQ-019 aborted  out  1  one-cycle pulse on abort completion.
REQ-020 xfer_count  out  LEN_W  number of words written in the current/last transfer.

Function
REQ-021 States SHALL be IDLE, RUN, FLUSH; busy SHALL be high exactly in RUN and FLUSH.
REQ-022 IDLE with start=1 and len!=0 SHALL latch src_base, dst_base, len, clear xfer_count, enter RUN, and drive rom_addr=src_base next cycle.
REQ-023 IDLE with start=1 and len=0 SHALL stay IDLE, issue no writes, and pulse done the next cycle.
REQ-024 RUN SHALL issue one read per cycle: read k at rom_addr=src_base+k, k=0..len-1.
REQ-025 Write k SHALL occur one cycle after read k: ram_we=1, ram_addr=dst_base+k, ram_din=rom_data.
REQ-026 RUN SHALL go to FLUSH after issuing read len-1; FLUSH SHALL perform the final write, then return to IDLE.
REQ-027 Address arithmetic SHALL wrap modulo 2^SRC_AW and 2^DST_AW respectively; no error on wrap.
REQ-028 Start sampled at edge T0 SHALL produce busy high for cycles 1..len+1, writes during cycles 2..len+1, done high in cycle len+2 only.
REQ-029 xfer_count SHALL increment by 1 on each write edge and hold its value in IDLE until the next accepted start.
REQ-030 start while busy SHALL be ignored; inputs src_base, dst_base and len SHALL be don't-care while busy.
REQ-031 abort in RUN or FLUSH SHALL force ram_we=0 from the next cycle; the write occurring in the abort cycle itself SHALL complete; the state SHALL go to IDLE and aborted SHALL pulse next cycle, with no done pulse.
REQ-032 abort in IDLE SHALL be ignored; abort and start together in IDLE SHALL start the transfer.
REQ-033 abort in the FLUSH cycle SHALL still complete the final write and SHALL pulse aborted, not done.
REQ-034 done and aborted SHALL never be high in the same cycle.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, busy=0, done=0, aborted=0, ram_we=0, rom_addr=0, ram_addr=0, xfer_count=0, independent of clk.
REQ-036 Reset mid-transfer SHALL discard the transfer with no further writes and no done or aborted pulse.

Verification
REQ-037 src_base=2, dst_base=0x10, len=4, ROM[2..5]=A1,B2,C3,D4 -> RAM[0x10..0x13]=A1,B2,C3,D4; done in cycle 6; xfer_count=4.
REQ-038 len=0 -> no ram_we; done pulse one cycle after start; busy never high.
REQ-039 src_base=14, dst_base=0xFE, len=4, defaults -> reads 14,15,0,1; writes 0xFE,0xFF,0x00,0x01.
REQ-040 len=8, abort asserted in cycle 4 -> exactly 3 writes (cycles 2..4), aborted in cycle 5, no done, xfer_count=3.
REQ-041 start pulsed again at cycle 3 of a len=5 transfer -> ignored; exactly 5 writes; a single done pulse.
REQ-042 rst asserted asynchronously mid-cycle during write 2 of len=6 -> outputs zero before the next edge; no further writes; no done pulse.
